// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster RGB stream: two line buffers plus a register window.
// Define BORDER_REPLICATE_EN to clamp out-of-image neighbours; otherwise they are zero-padded.
`timescale 1ns/1ps
module window_gen_3x3 #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel_1,
  output logic [PIX_W-1:0] out_pixel_2,
  output logic [PIX_W-1:0] out_pixel_3,
  output logic [PIX_W-1:0] out_pixel_4,
  output logic [PIX_W-1:0] out_pixel_5,
  output logic [PIX_W-1:0] out_pixel_6,
  output logic [PIX_W-1:0] out_pixel_7,
  output logic [PIX_W-1:0] out_pixel_8,
  output logic [PIX_W-1:0] out_pixel_9,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // One window column: pixels from the row above, the centre row and the row below.
  typedef struct packed {
    logic [PIX_W-1:0] t;
    logic [PIX_W-1:0] m;
    logic [PIX_W-1:0] b;
  } col_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, rd_addr;
  logic [ROW_W-1:0] row_q;
  logic [PIX_W-1:0] lb_top [IMG_W];
  logic [PIX_W-1:0] lb_mid [IMG_W];
  col_t             prev1_q, prev2_q, new_col;
  col_t             win_l, win_c, win_r;
  logic             accept, shift_en, trigger, last_win;
  logic             top_oob, bot_oob, left_oob, right_oob;

  // PAD and FLUSH reuse the RUN datapath: the window is always prev2 | prev1 | freshly read column.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    trigger   = 1'b0;
    last_win  = 1'b0;
    top_oob   = 1'b0;
    bot_oob   = 1'b0;
    left_oob  = 1'b0;
    right_oob = 1'b0;
    rd_addr   = col_q;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          shift_en = 1'b1;
          trigger  = (row_q != '0) && (col_q != '0);
          top_oob  = (row_q == ROW_ONE);
          left_oob = (col_q == COL_ONE);
          if (col_q == COL_LAST && row_q != '0) state_d = PAD;
        end
      end
      PAD: begin
        // Emit the row's rightmost window and preload column 0 for a possible flush.
        rd_addr   = '0;
        shift_en  = 1'b1;
        trigger   = 1'b1;
        top_oob   = (row_q == ROW_ONE);
        right_oob = 1'b1;
        state_d   = (row_q == ROW_LAST) ? FLUSH : RUN;
      end
      FLUSH: begin
        rd_addr   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        shift_en  = 1'b1;
        trigger   = 1'b1;
        bot_oob   = 1'b1;
        left_oob  = (col_q == '0);
        right_oob = (col_q == COL_LAST);
        if (col_q == COL_LAST) begin
          last_win = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign new_col = {lb_top[rd_addr], lb_mid[rd_addr], in_pixel};

  function automatic col_t fill_rows(input col_t x, input logic top_o, input logic bot_o);
    col_t y;
    y = x;
`ifdef BORDER_REPLICATE_EN
    if (top_o) y.t = x.m;
    if (bot_o) y.b = x.m;
`else
    if (top_o) y.t = '0;
    if (bot_o) y.b = '0;
`endif
    return y;
  endfunction

  function automatic col_t fill_col(input col_t x, input col_t centre, input logic oob);
    col_t y;
    y = x;
`ifdef BORDER_REPLICATE_EN
    if (oob) y = centre;
`else
    if (oob) y = '0;
`endif
    return y;
  endfunction

  // Rows are filled before columns so corners clamp to the nearest in-image pixel.
  always_comb begin
    win_c = fill_rows(prev1_q, top_oob, bot_oob);
    win_l = fill_col(fill_rows(prev2_q, top_oob, bot_oob), win_c, left_oob);
    win_r = fill_col(fill_rows(new_col, top_oob, bot_oob), win_c, right_oob);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= RUN;
      col_q   <= '0;
      row_q   <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
    end else begin
      state_q <= state_d;
      if (shift_en) begin
        prev2_q <= prev1_q;
        prev1_q <= new_col;
      end
      case (state_q)
        RUN: begin
          if (accept) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              // Rows >= 1 advance in PAD so PAD still knows which row it closes.
              if (row_q == '0) row_q <= ROW_ONE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        PAD:     row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        FLUSH:   col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: line buffers are deliberately not reset; stale rows are always masked as out-of-image.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      out_pixel_1 <= '0;
      out_pixel_2 <= '0;
      out_pixel_3 <= '0;
      out_pixel_4 <= '0;
      out_pixel_5 <= '0;
      out_pixel_6 <= '0;
      out_pixel_7 <= '0;
      out_pixel_8 <= '0;
      out_pixel_9 <= '0;
    end else begin
      out_valid  <= trigger;
      frame_done <= last_win;
      if (trigger) begin
        out_pixel_1 <= win_l.t;
        out_pixel_2 <= win_c.t;
        out_pixel_3 <= win_r.t;
        out_pixel_4 <= win_l.m;
        out_pixel_5 <= win_c.m;
        out_pixel_6 <= win_r.m;
        out_pixel_7 <= win_l.b;
        out_pixel_8 <= win_c.b;
        out_pixel_9 <= win_r.b;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x4 frame with pixel (r,c) = {3{4r+c+1}}.
`timescale 1ns/1ps
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 24;
  localparam int CW = 9 * P;

  typedef logic [CW-1:0] cv_t;
  typedef struct packed {
    cv_t  win;
    logic fd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [P-1:0] in_pixel;
  logic         in_ready, out_valid, frame_done;
  logic [P-1:0] op1, op2, op3, op4, op5, op6, op7, op8, op9;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pixel_1(op1), .out_pixel_2(op2), .out_pixel_3(op3),
    .out_pixel_4(op4), .out_pixel_5(op5), .out_pixel_6(op6),
    .out_pixel_7(op7), .out_pixel_8(op8), .out_pixel_9(op9),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   win_cnt  = 0;
  int   fd_cnt   = 0;
  bit   grab_first = 1'b0;
  cv_t  first_win, fd_win, act_win;

  task automatic check(input string name, input cv_t act, input cv_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [P-1:0] hv(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b};
  endfunction

  function automatic logic [P-1:0] pix(input int r, input int c);
    return hv(W * r + c + 1);
  endfunction

  function automatic cv_t model_win(input int r, input int c);
    cv_t          w;
    logic [P-1:0] p;
    int           rr, cc;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
`ifdef BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        p = pix(rr, cc);
`else
        p = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? '0 : pix(rr, cc);
`endif
        w = {w[8*P-1:0], p};
      end
    end
    return w;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.win = model_win(r, c);
        e.fd  = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: pops one expected window per out_valid, sampled on the falling edge.
  always @(negedge clk) begin
    act_win = {op1, op2, op3, op4, op5, op6, op7, op8, op9};
    if (frame_done && !out_valid) check("frame_done_without_valid", cv_t'(1), cv_t'(0));
    if (out_valid) begin
      win_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_win = act_win;
      end
      if (grab_first) begin
        first_win  = act_win;
        grab_first = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_window", act_win, cv_t'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("window", act_win, mon_e.win);
        check("window_frame_done", cv_t'(frame_done), cv_t'(mon_e.fd));
      end
    end
  end

  // Bubbles randomise in_valid; while stalled, in_valid is forced high with junk data.
  task automatic drive_frame(input bit bubbles, input int stop_after);
    int idx   = 0;
    int guard = 0;
    int lim;
    lim = (stop_after == 0) ? W * H : stop_after;
    while (idx < lim) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        check("drive_timeout", cv_t'(idx), cv_t'(lim));
        break;
      end
      if (in_ready) begin
        in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_pixel = pix(idx / W, idx % W);
        if (in_valid) idx++;
      end else begin
        in_valid = 1'b1;
        in_pixel = 24'hBAD000 | P'(idx);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check(name, cv_t'(exp_q.size()), cv_t'(0));
  endtask

  task automatic check_idle(input string name);
    check({name, "_out_valid"}, cv_t'(out_valid), cv_t'(0));
    check({name, "_frame_done"}, cv_t'(frame_done), cv_t'(0));
    check({name, "_window"}, {op1, op2, op3, op4, op5, op6, op7, op8, op9}, cv_t'(0));
    check({name, "_in_ready"}, cv_t'(in_ready), cv_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1);
  end

  initial begin
    cv_t         first_exp, last_exp;
    logic [23:0] rdy_hist, rdy_exp;

`ifdef BORDER_REPLICATE_EN
    first_exp = {hv(1), hv(1), hv(2), hv(1), hv(1), hv(2), hv(5), hv(5), hv(6)};
    last_exp  = {hv(11), hv(12), hv(12), hv(15), hv(16), hv(16), hv(15), hv(16), hv(16)};
`else
    first_exp = {hv(0), hv(0), hv(0), hv(0), hv(1), hv(2), hv(0), hv(5), hv(6)};
    last_exp  = {hv(11), hv(12), hv(0), hv(15), hv(16), hv(0), hv(0), hv(0), hv(0)};
`endif
    for (int i = 0; i < 24; i++) rdy_exp[i] = !(i == 8 || i == 13 || (i >= 18 && i <= 22));

    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // Frame with in_valid held high, recording the in_ready profile; then a bubbly frame right after.
    grab_first = 1'b1;
    push_frame();
    fork
      drive_frame(1'b0, 0);
      begin
        for (int i = 0; i < 24; i++) begin
          @(negedge clk);
          rdy_hist[i] = in_ready;
        end
      end
    join
    check("in_ready_profile", cv_t'(rdy_hist), cv_t'(rdy_exp));
    check("first_window", first_win, first_exp);
    push_frame();
    drive_frame(1'b1, 0);
    drain("drain_two_frames");
    check("window_count_two_frames", cv_t'(win_cnt), cv_t'(2 * W * H));
    check("frame_done_count_two_frames", cv_t'(fd_cnt), cv_t'(2));
    check("last_window", fd_win, last_exp);

    // Reset after 6 accepts, then a fresh frame must reproduce the first one.
    push_frame();
    drive_frame(1'b0, 6);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle("midframe_reset");
    #2 rst = 1'b0;
    win_cnt    = 0;
    fd_cnt     = 0;
    fd_win     = '0;
    grab_first = 1'b1;
    push_frame();
    drive_frame(1'b0, 0);
    drain("drain_after_reset");
    check("window_count_after_reset", cv_t'(win_cnt), cv_t'(W * H));
    check("frame_done_count_after_reset", cv_t'(fd_cnt), cv_t'(1));
    check("first_window_after_reset", first_win, first_exp);
    check("last_window_after_reset", fd_win, last_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
